cordic_job_arbiter: RTL and testbench

Shares one CORDIC Controller (bus-side port: x/y/z inputs, control-register input, x/y/z outputs, control-register output) between p_NUM_REQ requesters. Round-robin grants, loads operands and control word, pulses start, waits for the READY flag or a timeout, then returns results and status to the granted requester. Sits between the accelerator bus slaves and the Controller; the Controller's own clk/rst are driven by the same clk/rst.

---
 rtl/cordic_job_arbiter.sv | 156 +++++++++++++++
 tb/tb_cordic_job_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_job_arbiter.sv
// Round-robin front end that shares one CORDIC Controller between p_NUM_REQ requesters:
// grants a job, loads operands, pulses START, waits for READY or a timeout, returns results.
module cordic_job_arbiter #(
   parameter int p_WIDTH     = 32,
   parameter int p_NUM_REQ   = 4,
   parameter int p_START_BIT = 0,
   parameter int p_READY_BIT = 0,
   parameter int p_TIMEOUT   = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [p_NUM_REQ-1:0]           req,
   input  logic [p_NUM_REQ*p_WIDTH-1:0]   req_x,
   input  logic [p_NUM_REQ*p_WIDTH-1:0]   req_y,
   input  logic [p_NUM_REQ*p_WIDTH-1:0]   req_z,
   input  logic [p_NUM_REQ*p_WIDTH-1:0]   req_ctrl,
   output logic [p_NUM_REQ-1:0]           gnt,
   output logic [p_NUM_REQ-1:0]           done,
   output logic [p_WIDTH-1:0]             res_x,
   output logic [p_WIDTH-1:0]             res_y,
   output logic [p_WIDTH-1:0]             res_z,
   output logic [p_WIDTH-1:0]             res_status,
   output logic                           res_timeout,
   output logic                           busy,
   output logic [$clog2(p_NUM_REQ)-1:0]   cur_id,
   output logic [p_WIDTH-1:0]             ctl_x_in,
   output logic [p_WIDTH-1:0]             ctl_y_in,
   output logic [p_WIDTH-1:0]             ctl_z_in,
   output logic [p_WIDTH-1:0]             ctl_ctrl_in,
   input  logic [p_WIDTH-1:0]             ctl_x_out,
   input  logic [p_WIDTH-1:0]             ctl_y_out,
   input  logic [p_WIDTH-1:0]             ctl_z_out,
   input  logic [p_WIDTH-1:0]             ctl_ctrl_out
);

   localparam int c_ID_W  = $clog2(p_NUM_REQ);
   localparam int c_CNT_W = $clog2(p_TIMEOUT);
   localparam logic [p_NUM_REQ-1:0] c_ONE_HOT0  = {{(p_NUM_REQ-1){1'b0}}, 1'b1};
   localparam logic [p_WIDTH-1:0]   c_START_MSK = {{(p_WIDTH-1){1'b0}}, 1'b1} << p_START_BIT;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_START   = 3'd2,
      S_WAIT    = 3'd3,
      S_CAPTURE = 3'd4
   } state_t;

   state_t               state_r;
   logic [c_ID_W-1:0]    rr_r;
   logic [c_CNT_W-1:0]   cnt_r;
   logic                 timeout_r;
   logic [c_ID_W-1:0]    sel_s;
   logic                 sel_vld_s;
   logic [c_ID_W-1:0]    idx_s;
   logic                 hit_s;
   logic                 ready_s;
   logic [c_ID_W-1:0]    rr_nxt_s;

   assign ready_s  = ctl_ctrl_out[p_READY_BIT];
   assign rr_nxt_s = (cur_id == c_ID_W'(p_NUM_REQ - 1)) ? {c_ID_W{1'b0}} : cur_id + c_ID_W'(1);

   // Round-robin pick: scan from the farthest offset down so the nearest request at/after rr_r wins.
   always_comb begin
      sel_s     = {c_ID_W{1'b0}};
      sel_vld_s = 1'b0;
      idx_s     = {c_ID_W{1'b0}};
      hit_s     = 1'b0;
      for (int k = p_NUM_REQ - 1; k >= 0; k--) begin
         idx_s     = c_ID_W'((int'(rr_r) + k) % p_NUM_REQ);
         hit_s     = req[idx_s];
         sel_s     = hit_s ? idx_s : sel_s;
         sel_vld_s = sel_vld_s | hit_s;
      end
   end

   // Job sequencer: grant, drive the Controller, wait for READY/timeout, return results.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= S_IDLE;
         rr_r        <= {c_ID_W{1'b0}};
         cnt_r       <= {c_CNT_W{1'b0}};
         timeout_r   <= 1'b0;
         gnt         <= {p_NUM_REQ{1'b0}};
         done        <= {p_NUM_REQ{1'b0}};
         res_x       <= {p_WIDTH{1'b0}};
         res_y       <= {p_WIDTH{1'b0}};
         res_z       <= {p_WIDTH{1'b0}};
         res_status  <= {p_WIDTH{1'b0}};
         res_timeout <= 1'b0;
         busy        <= 1'b0;
         cur_id      <= {c_ID_W{1'b0}};
         ctl_x_in    <= {p_WIDTH{1'b0}};
         ctl_y_in    <= {p_WIDTH{1'b0}};
         ctl_z_in    <= {p_WIDTH{1'b0}};
         ctl_ctrl_in <= {p_WIDTH{1'b0}};
      end else begin
         gnt  <= {p_NUM_REQ{1'b0}};
         done <= {p_NUM_REQ{1'b0}};
         case (state_r)
            S_IDLE: begin
               if (sel_vld_s) begin
                  gnt         <= c_ONE_HOT0 << sel_s;
                  cur_id      <= sel_s;
                  ctl_x_in    <= req_x[sel_s*p_WIDTH +: p_WIDTH];
                  ctl_y_in    <= req_y[sel_s*p_WIDTH +: p_WIDTH];
                  ctl_z_in    <= req_z[sel_s*p_WIDTH +: p_WIDTH];
                  ctl_ctrl_in <= req_ctrl[sel_s*p_WIDTH +: p_WIDTH] & ~c_START_MSK;
                  busy        <= 1'b1;
                  state_r     <= S_LOAD;
               end else begin
                  state_r     <= S_IDLE;
               end
            end
            S_LOAD: begin
               ctl_ctrl_in[p_START_BIT] <= 1'b1;
               state_r                  <= S_START;
            end
            S_START: begin
               cnt_r   <= {c_CNT_W{1'b0}};
               state_r <= S_WAIT;
            end
            S_WAIT: begin
               // cnt_r==0 marks the first WAIT cycle, where READY may still be left over from the last job
               if ((cnt_r != {c_CNT_W{1'b0}}) && ready_s) begin
                  timeout_r                <= 1'b0;
                  ctl_ctrl_in[p_START_BIT] <= 1'b0;
                  state_r                  <= S_CAPTURE;
               end else if (cnt_r == c_CNT_W'(p_TIMEOUT - 1)) begin
                  timeout_r                <= 1'b1;
                  ctl_ctrl_in[p_START_BIT] <= 1'b0;
                  state_r                  <= S_CAPTURE;
               end else begin
                  cnt_r                    <= cnt_r + c_CNT_W'(1);
               end
            end
            S_CAPTURE: begin
               res_x       <= ctl_x_out;
               res_y       <= ctl_y_out;
               res_z       <= ctl_z_out;
               res_status  <= ctl_ctrl_out;
               res_timeout <= timeout_r;
               done        <= c_ONE_HOT0 << cur_id;
               rr_r        <= rr_nxt_s;
               busy        <= 1'b0;
               state_r     <= S_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_job_arbiter.sv
// Self-checking bench for cordic_job_arbiter: a stub Controller with programmable READY latency,
// and a job-level reference model (round-robin pick, WAIT length, expected results).
module tb_cordic_job_arbiter;
   localparam int W  = 32;
   localparam int N  = 4;
   localparam int TO = 64;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*W-1:0]  req_x = '0, req_y = '0, req_z = '0, req_ctrl = '0;
   logic [N-1:0]    gnt, done;
   logic [W-1:0]    res_x, res_y, res_z, res_status;
   logic            res_timeout, busy;
   logic [1:0]      cur_id;
   logic [W-1:0]    ctl_x_in, ctl_y_in, ctl_z_in, ctl_ctrl_in;
   logic [W-1:0]    ctl_x_out, ctl_y_out, ctl_z_out, ctl_ctrl_out;

   int n_checks = 0;
   int n_pass   = 0;
   int m_ptr    = 0;
   int stub_lat = 0;
   int stub_cnt = 0;
   logic stub_ready;

   always #5 clk = ~clk;

   cordic_job_arbiter #(.p_WIDTH(W), .p_NUM_REQ(N), .p_START_BIT(0), .p_READY_BIT(0), .p_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req),
      .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_ctrl(req_ctrl),
      .gnt(gnt), .done(done),
      .res_x(res_x), .res_y(res_y), .res_z(res_z), .res_status(res_status),
      .res_timeout(res_timeout), .busy(busy), .cur_id(cur_id),
      .ctl_x_in(ctl_x_in), .ctl_y_in(ctl_y_in), .ctl_z_in(ctl_z_in), .ctl_ctrl_in(ctl_ctrl_in),
      .ctl_x_out(ctl_x_out), .ctl_y_out(ctl_y_out), .ctl_z_out(ctl_z_out), .ctl_ctrl_out(ctl_ctrl_out)
   );

   // Stub Controller: READY rises once START has been seen high for stub_lat cycles.
   always @(posedge clk) stub_cnt <= ctl_ctrl_in[0] ? stub_cnt + 1 : 0;
   assign stub_ready   = (stub_cnt >= stub_lat);
   assign ctl_x_out    = ~ctl_x_in;
   assign ctl_y_out    = ctl_y_in + ctl_z_in;
   assign ctl_z_out    = ctl_x_in ^ ctl_ctrl_in;
   assign ctl_ctrl_out = {ctl_x_in[W-1:1], stub_ready};

   function automatic int pick(input logic [N-1:0] m, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (m[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic set_ops(input int id, input logic [W-1:0] xv, yv, zv, cv);
      req_x[id*W +: W]    = xv;
      req_y[id*W +: W]    = yv;
      req_z[id*W +: W]    = zv;
      req_ctrl[id*W +: W] = cv;
   endtask

   task automatic rand_ops(input int id);
      set_ops(id, $urandom, $urandom, $urandom, $urandom);
   endtask

   // Request mask m from an idle arbiter, expect the model's grant on the next cycle, then drop req.
   task automatic grant_expect(input logic [N-1:0] m, output int id);
      logic [N-1:0] eg;
      req = m;
      @(negedge clk);
      id = pick(m, m_ptr);
      eg = 4'b0001 << id;
      n_checks++;
      if (gnt !== eg) $display("FAIL gnt: got %b want %b (mask %b)", gnt, eg, m);
      else n_pass++;
      req = '0;
   endtask

   // Follow one granted job from the LOAD cycle to its done cycle.
   task automatic serve(input int id, input int lat);
      logic [W-1:0] xv, yv, zv, cv, cm;
      int w;
      bit tmo, rdy, bad;
      xv  = req_x[id*W +: W];
      yv  = req_y[id*W +: W];
      zv  = req_z[id*W +: W];
      cv  = req_ctrl[id*W +: W];
      cm  = cv & ~32'h0000_0001;
      tmo = (lat > TO);
      w   = tmo ? TO : ((lat < 2) ? 2 : lat);
      rdy = (w + 1 >= lat);
      stub_lat = lat;
      n_checks++;
      if (cur_id !== 2'(id) || busy !== 1'b1)
         $display("FAIL load_id: cur_id=%0d busy=%b want %0d/1", cur_id, busy, id);
      else n_pass++;
      n_checks++;
      if ({ctl_x_in, ctl_y_in, ctl_z_in, ctl_ctrl_in} !== {xv, yv, zv, cm})
         $display("FAIL load_ops: got %h %h %h %h want %h %h %h %h",
                  ctl_x_in, ctl_y_in, ctl_z_in, ctl_ctrl_in, xv, yv, zv, cm);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (ctl_ctrl_in !== (cv | 32'h0000_0001) || gnt !== 4'b0000)
         $display("FAIL start_cycle: ctrl_in=%h gnt=%b want %h/0000", ctl_ctrl_in, gnt, cv | 32'h1);
      else n_pass++;
      bad = 1'b0;
      for (int k = 0; k < w; k++) begin
         @(negedge clk);
         if (done !== 4'b0000 || ctl_ctrl_in[0] !== 1'b1 || busy !== 1'b1) bad = 1'b1;
      end
      @(negedge clk);
      if (done !== 4'b0000 || ctl_ctrl_in[0] !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      n_checks++;
      if (bad) $display("FAIL wait_window: job %0d lat %0d expected %0d WAIT cycles then CAPTURE", id, lat, w);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (done !== (4'b0001 << id)) $display("FAIL done: got %b want %b (lat %0d)", done, 4'b0001 << id, lat);
      else n_pass++;
      n_checks++;
      if ({res_x, res_y, res_z} !== {~xv, yv + zv, xv ^ cm})
         $display("FAIL results: got %h %h %h want %h %h %h", res_x, res_y, res_z, ~xv, yv + zv, xv ^ cm);
      else n_pass++;
      n_checks++;
      if (res_status !== {xv[W-1:1], rdy} || res_timeout !== tmo)
         $display("FAIL status: got %h/%b want %h/%b", res_status, res_timeout, {xv[W-1:1], rdy}, tmo);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0 || ctl_ctrl_in[0] !== 1'b0)
         $display("FAIL idle_after_done: busy=%b start=%b want 0/0", busy, ctl_ctrl_in[0]);
      else n_pass++;
      m_ptr = (id + 1) % N;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({gnt, done, res_x, res_y, res_z, res_status, res_timeout, busy, cur_id,
           ctl_x_in, ctl_y_in, ctl_z_in, ctl_ctrl_in} !== '0)
         $display("FAIL reset_state: gnt=%b done=%b busy=%b cur_id=%0d ctrl_in=%h", gnt, done, busy, cur_id, ctl_ctrl_in);
      else n_pass++;
      rst = 1'b1;
      m_ptr = 0;
      @(negedge clk);
   endtask

   task automatic test_single_job;
      int id;
      set_ops(0, 32'h4DBA_76D4, 32'h0000_0000, 32'hE000_0000, 32'h0000_1E03);
      grant_expect(4'b0001, id);
      serve(id, $urandom_range(2, 10));
   endtask

   task automatic test_back_to_back;
      int id;
      rand_ops(0);
      rand_ops(1);
      grant_expect(4'b0001, id);
      serve(id, $urandom_range(0, 6));
      grant_expect(4'b0010, id);
      serve(id, $urandom_range(0, 6));
   endtask

   task automatic test_round_robin;
      int id;
      logic [N-1:0] eg;
      for (int i = 0; i < N; i++) rand_ops(i);
      req = 4'b1111;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         id = pick(4'b1111, m_ptr);
         eg = 4'b0001 << id;
         n_checks++;
         if (gnt !== eg) $display("FAIL rr_order: job %0d got %b want %b", j, gnt, eg);
         else n_pass++;
         if (j == 7) req = '0;
         serve(id, $urandom_range(0, 8));
      end
      req = '0;
   endtask

   task automatic test_random_masks;
      int id;
      for (int j = 0; j < 10; j++) begin
         for (int i = 0; i < N; i++) rand_ops(i);
         grant_expect(4'($urandom_range(1, 15)), id);
         serve(id, $urandom_range(0, 12));
      end
   endtask

   task automatic test_stale_ready;
      int id;
      rand_ops(2);
      stub_lat = 0;
      grant_expect(4'b0100, id);
      serve(id, 0);
   endtask

   task automatic test_timeout;
      int id;
      int lats [3] = '{1000, TO, TO + 1};
      for (int j = 0; j < 3; j++) begin
         rand_ops(3);
         grant_expect(4'b1000, id);
         serve(id, lats[j]);
      end
   endtask

   task automatic test_reset_in_wait;
      int id;
      bit bad;
      rand_ops(1);
      grant_expect(4'b0010, id);
      serve(id, 3);
      rand_ops(3);
      grant_expect(4'b1000, id);
      stub_lat = 1000;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({gnt, done, res_x, res_y, res_z, res_status, res_timeout, busy, cur_id,
           ctl_x_in, ctl_y_in, ctl_z_in, ctl_ctrl_in} !== '0)
         $display("FAIL reset_in_wait: gnt=%b done=%b busy=%b cur_id=%0d ctrl_in=%h", gnt, done, busy, cur_id, ctl_ctrl_in);
      else n_pass++;
      rst = 1'b1;
      m_ptr = 0;
      bad = 1'b0;
      repeat (80) begin
         @(negedge clk);
         if (done !== 4'b0000 || busy !== 1'b0) bad = 1'b1;
      end
      n_checks++;
      if (bad) $display("FAIL no_done_after_reset: done or busy seen after mid-job reset, want none");
      else n_pass++;
      rand_ops(0);
      rand_ops(2);
      grant_expect(4'b0101, id);
      serve(id, 2);
      grant_expect(4'b0100, id);
      serve(id, 5);
   endtask

   initial begin
      test_reset;
      test_single_job;
      test_back_to_back;
      test_round_robin;
      test_random_masks;
      test_stale_ready;
      test_timeout;
      test_reset_in_wait;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
